alu_operand_seq: RTL and testbench
==================================

ALU_OPERAND_SEQ -- requirements
Module: alu_operand_seq

Interface
REQ-001 Parameter: ALU_LAT, 1, clock cycles from ALU_A/ALU_B/ALU_OP stable to ALU_OUT valid (legal range 1-4).
REQ-002 Parameter: NUM_OPS, 7, count of legal ALU_OP codes (0..NUM_OPS-1).
REQ-003 Port: clk  input  1  single clock, all logic on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: CMD_VALID  input  1  command present.
REQ-006 Port: CMD_READY  output  1  block accepts command this cycle.
REQ-007 Port: CMD_OP  input  5  ALU operation code.
REQ-008 Port: CMD_RS / CMD_RT / CMD_RD  input  5 each  source A, source B, destination register indices.
REQ-009 Port: CMD_USE_IMM  input  1  B operand is immediate, not register RT.
REQ-010 Port: CMD_IMM  input  16  immediate, sign-extended to 32 bits.
REQ-011 Port: ALU_A / ALU_B  output  32 each  operands to downstream ALU.
REQ-012 Port: ALU_OP  output  5  operation code to downstream ALU.
REQ-013 Port: ALU_OUT  input  32  result from downstream ALU.
REQ-014 Port: DONE  output  1  one-cycle pulse, command written back.
REQ-015 Port: RESULT  output  32  last written-back value, held until next DONE.
REQ-016 Port: ERR  output  1  one-cycle pulse, command rejected (illegal op).
REQ-017 Port: DBG_ADDR  input  5 / DBG_DATA  output  32  combinational register-file read port.

Function
REQ-018 Block SHALL contain a 32x32 register file; register 0 reads 0 always, writes to it discarded.
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, WB, ERR.
REQ-020 CMD_READY SHALL be 1 only in IDLE; transfer occurs when CMD_VALID && CMD_READY at a rising edge; all CMD_* fields captured then.
REQ-021 IDLE -> ERR when captured CMD_OP >= NUM_OPS; ERR asserts ERR for exactly one cycle, no register write, -> IDLE.
REQ-022 IDLE -> ISSUE for legal op; in ISSUE ALU_A = reg[RS], ALU_B = USE_IMM ? sext(IMM) : reg[RT], ALU_OP = captured op, all registered and held stable through WAIT.
REQ-023 ISSUE -> WAIT; WAIT lasts ALU_LAT-1 cycles (zero cycles when ALU_LAT=1, i.e. ISSUE -> WB directly) via a down-counter.
REQ-024 In WB: ALU_OUT sampled, written to reg[RD] (unless RD=0), RESULT updated, DONE pulsed one cycle, -> IDLE.
REQ-025 Latency, ALU_LAT=1: accept at edge N, ALU operands valid after N+1, DONE high in cycle after edge N+2; one command per 3 cycles; each extra ALU_LAT cycle adds one.
REQ-026 Commands SHALL execute strictly in order; a command reads results written by any earlier command (no hazard possible, single outstanding command).
REQ-027 RS=RD or RT=RD SHALL read the old value and write the new one.
REQ-028 DBG_DATA SHALL reflect a write on the cycle after the WB edge; DBG_ADDR=0 returns 0.
REQ-029 ALU_A, ALU_B, ALU_OP SHALL retain last issued values in IDLE/ERR.

Reset
REQ-030 While rst high at an edge: state IDLE, all 32 registers 0, ALU_A/ALU_B/RESULT 0, ALU_OP 0, DONE/ERR 0, WAIT counter 0, CMD_READY 0.
REQ-031 CMD_READY SHALL be 1 in the first cycle after rst deasserts.
REQ-032 Reset mid-command SHALL abort it: no writeback, no DONE, no ERR.

Structure
REQ-033 Shared package SHALL hold: FSM state enum, NUM_OPS default, op-code constants 0..6, register-index width (5) and data width (32).
REQ-034 Register file SHALL be one sub-module, alu_regfile (2 combinational read ports plus debug read, 1 synchronous write port, reg 0 forced zero, synchronous clear on rst).

Verification (bench stub ALU: ALU_OUT registered = ALU_A + ALU_B, ALU_LAT=1)
REQ-035 rst 2 cycles -> CMD_READY 0 during, 1 next cycle; DBG_DATA 0 for all 32 addresses.
REQ-036 cmd op=2 RS=0 USE_IMM=1 IMM=16'h0070 RD=1, then op=2 RS=1 IMM=16'h0007 RD=2 -> DONE twice, RESULT 32'h70 then 32'h77, DBG reg2=32'h77.
REQ-037 cmd IMM=16'hFFFF RS=0 RD=3 -> ALU_B=32'hFFFFFFFF, reg3=32'hFFFFFFFF; then RD=0 -> DONE pulses, reg0 still 0.
REQ-038 cmd op=7 -> ERR one cycle, no DONE, all registers unchanged; op=6 accepted normally.
REQ-039 CMD_VALID held high continuously, 4 commands -> CMD_READY high once every 3 cycles, exactly 4 DONE pulses in order, RS=RD command uses pre-write value.
REQ-040 rst asserted in ISSUE of a command to RD=5 -> no DONE, reg5 0, CMD_READY 1 cycle after rst drops.

Source files
------------

// File: rtl/alu_operand_seq_pkg.sv
// Shared definitions for the ALU operand sequencer.
// Contents: data / register-index widths, default legal op count, op-code
// constants, the sequencer FSM state type and the immediate sign-extender.
package alu_operand_seq_pkg;

    localparam int DATA_W      = 32;
    localparam int REG_IDX_W   = 5;
    localparam int OP_W        = 5;
    localparam int IMM_W       = 16;
    localparam int NUM_REGS    = 32;
    localparam int NUM_OPS_DEF = 7;

    localparam logic [OP_W-1:0] OP_AND = 5'd0;
    localparam logic [OP_W-1:0] OP_OR  = 5'd1;
    localparam logic [OP_W-1:0] OP_ADD = 5'd2;
    localparam logic [OP_W-1:0] OP_SUB = 5'd3;
    localparam logic [OP_W-1:0] OP_XOR = 5'd4;
    localparam logic [OP_W-1:0] OP_SLT = 5'd5;
    localparam logic [OP_W-1:0] OP_NOR = 5'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WB,
        S_ERR
    } state_t;

    function automatic logic signed [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/alu_operand_seq_regfile.sv
// 32 x 32-bit register file for the ALU operand sequencer.
// Ports:
//   clk, rst              clock, synchronous active-high clear of all entries
//   i_ra_addr/o_ra_data   combinational read port A
//   i_rb_addr/o_rb_data   combinational read port B
//   i_dbg_addr/o_dbg_data combinational debug read port
//   i_we/i_wa/i_wd        synchronous write port
// Register 0 always reads zero; writes addressed to it are dropped.
module alu_regfile
    import alu_operand_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] i_ra_addr,
    output logic [DATA_W-1:0]    o_ra_data,
    input  logic [REG_IDX_W-1:0] i_rb_addr,
    output logic [DATA_W-1:0]    o_rb_data,
    input  logic [REG_IDX_W-1:0] i_dbg_addr,
    output logic [DATA_W-1:0]    o_dbg_data,
    input  logic                 i_we,
    input  logic [REG_IDX_W-1:0] i_wa,
    input  logic [DATA_W-1:0]    i_wd
);

    logic [DATA_W-1:0] r_mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_wa != '0)) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    // Entry 0 is never written after reset, but the read mux still forces
    // zero so the guarantee does not depend on the write guard alone.
    assign o_ra_data  = (i_ra_addr  == '0) ? '0 : r_mem[i_ra_addr];
    assign o_rb_data  = (i_rb_addr  == '0) ? '0 : r_mem[i_rb_addr];
    assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_operand_seq.sv
// ALU operand sequencer: accepts one register-to-register (or register-
// immediate) command at a time, presents operands to an external ALU with
// fixed latency ALU_LAT, writes the result back to its register file.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   CMD_VALID/CMD_READY          command handshake (ready only in IDLE)
//   CMD_OP/RS/RT/RD/USE_IMM/IMM  command fields, captured at transfer
//   ALU_A/ALU_B/ALU_OP           registered operands to the external ALU
//   ALU_OUT                      external ALU result
//   DONE/RESULT                  writeback pulse and last written value
//   ERR                          pulse for a command with an illegal op
//   DBG_ADDR/DBG_DATA            combinational register-file peek
module alu_operand_seq
    import alu_operand_seq_pkg::*;
#(
    parameter int ALU_LAT = 1,            // legal range 1..4
    parameter int NUM_OPS = NUM_OPS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 CMD_VALID,
    output logic                 CMD_READY,
    input  logic [OP_W-1:0]      CMD_OP,
    input  logic [REG_IDX_W-1:0] CMD_RS,
    input  logic [REG_IDX_W-1:0] CMD_RT,
    input  logic [REG_IDX_W-1:0] CMD_RD,
    input  logic                 CMD_USE_IMM,
    input  logic [IMM_W-1:0]     CMD_IMM,
    output logic [DATA_W-1:0]    ALU_A,
    output logic [DATA_W-1:0]    ALU_B,
    output logic [OP_W-1:0]      ALU_OP,
    input  logic [DATA_W-1:0]    ALU_OUT,
    output logic                 DONE,
    output logic [DATA_W-1:0]    RESULT,
    output logic                 ERR,
    input  logic [REG_IDX_W-1:0] DBG_ADDR,
    output logic [DATA_W-1:0]    DBG_DATA
);

    // WAIT spans ALU_LAT-1 cycles; the counter is loaded with one less
    // because the cycle in which it reads zero is itself a WAIT cycle.
    localparam logic [1:0] WAIT_INIT = (ALU_LAT > 1) ? 2'(ALU_LAT - 2) : 2'd0;

    state_t                 r_state;
    logic [1:0]             r_wait_cnt;
    logic [OP_W-1:0]        r_op;
    logic [REG_IDX_W-1:0]   r_rs;
    logic [REG_IDX_W-1:0]   r_rt;
    logic [REG_IDX_W-1:0]   r_rd;
    logic                   r_use_imm;
    logic [IMM_W-1:0]       r_imm;
    logic [DATA_W-1:0]      r_alu_a;
    logic signed [DATA_W-1:0] r_alu_b;
    logic [OP_W-1:0]        r_alu_op;
    logic [DATA_W-1:0]      r_result;
    logic                   r_done;
    logic                   r_err;

    logic                   w_accept;
    logic                   w_op_legal;
    logic [DATA_W-1:0]      w_rs_data;
    logic [DATA_W-1:0]      w_rt_data;
    logic                   w_we;

    // Ready is gated by rst directly so it is low throughout reset and high
    // in the very first cycle after reset is released.
    assign CMD_READY  = (r_state == S_IDLE) && !rst;
    assign w_accept   = CMD_VALID && CMD_READY;
    assign w_op_legal = int'(CMD_OP) < NUM_OPS;
    assign w_we       = (r_state == S_WB);

    alu_regfile u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_ra_addr  (r_rs),
        .o_ra_data  (w_rs_data),
        .i_rb_addr  (r_rt),
        .o_rb_data  (w_rt_data),
        .i_dbg_addr (DBG_ADDR),
        .o_dbg_data (DBG_DATA),
        .i_we       (w_we),
        .i_wa       (r_rd),
        .i_wd       (ALU_OUT)
    );

    // Command capture: data only, qualified by the handshake.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op      <= CMD_OP;
            r_rs      <= CMD_RS;
            r_rt      <= CMD_RT;
            r_rd      <= CMD_RD;
            r_use_imm <= CMD_USE_IMM;
            r_imm     <= CMD_IMM;
        end
    end

    // Sequencer FSM with registered operand / status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_result   <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_op_legal) begin
                            r_state <= S_ISSUE;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    // RS/RD aliasing is safe: reads happen here, the write
                    // only in WB, and only one command is ever in flight.
                    r_alu_a  <= w_rs_data;
                    r_alu_b  <= r_use_imm ? sext_imm(r_imm) : w_rt_data;
                    r_alu_op <= r_op;
                    if (ALU_LAT <= 1) begin
                        r_state <= S_WB;
                    end else begin
                        r_wait_cnt <= WAIT_INIT;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_state <= S_WB;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 2'd1;
                    end
                end
                S_WB: begin
                    r_result <= ALU_OUT;
                    r_done   <= 1'b1;
                    r_state  <= S_IDLE;
                end
                S_ERR: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ALU_A  = r_alu_a;
    assign ALU_B  = r_alu_b;
    assign ALU_OP = r_alu_op;
    assign RESULT = r_result;
    assign DONE   = r_done;
    assign ERR    = r_err;

endmodule

// File: tb/tb_alu_operand_seq.sv
module tb_alu_operand_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_op, cmd_rs, cmd_rt, cmd_rd;
    logic        cmd_use_imm;
    logic [15:0] cmd_imm;
    logic [31:0] alu_a, alu_b, alu_out, result, dbg_data;
    logic [4:0]  alu_op, dbg_addr;
    logic        done, err;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] model_reg [32];

    always #5 clk = ~clk;

    // Stub ALU: registered A+B, updated mid-cycle so it settles within one
    // clock of the operands changing (ALU_LAT = 1).
    always @(negedge clk) alu_out <= alu_a + alu_b;

    alu_operand_seq #(.ALU_LAT(1), .NUM_OPS(7)) dut (
        .clk(clk), .rst(rst),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
        .CMD_OP(cmd_op), .CMD_RS(cmd_rs), .CMD_RT(cmd_rt), .CMD_RD(cmd_rd),
        .CMD_USE_IMM(cmd_use_imm), .CMD_IMM(cmd_imm),
        .ALU_A(alu_a), .ALU_B(alu_b), .ALU_OP(alu_op), .ALU_OUT(alu_out),
        .DONE(done), .RESULT(result), .ERR(err),
        .DBG_ADDR(dbg_addr), .DBG_DATA(dbg_data)
    );

    function automatic logic [31:0] sx(input logic [15:0] v);
        return 32'($signed(v));
    endfunction

    // Reference: operand fetch before write, op >= 7 rejected, reg 0 fixed at 0.
    task automatic model_apply(input logic [4:0] op, rs, rt, rd, input bit ui,
                               input logic [15:0] imm, output bit e_err,
                               output logic [31:0] e_val);
        logic [31:0] a, b;
        e_err = (op >= 5'd7);
        e_val = '0;
        if (!e_err) begin
            a = model_reg[rs];
            b = ui ? sx(imm) : model_reg[rt];
            e_val = a + b;
            if (rd != 5'd0) model_reg[rd] = e_val;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model_reg[i] = '0;
    endtask

    // Drive one command through the handshake and report its outcome.
    task automatic do_cmd(input logic [4:0] op, rs, rt, rd, input bit ui,
                          input logic [15:0] imm, output bit got_done,
                          output bit got_err, output int lat);
        int w;
        got_done = 0; got_err = 0; lat = -1; w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) return;
        cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
        cmd_use_imm = ui; cmd_imm = imm; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (done) begin got_done = 1; lat = c; break; end
            if (err)  begin got_err  = 1; lat = c; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low: got %b want 0", cmd_ready); end
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b want 1", cmd_ready); end
        n_cmp++;
        if ({alu_a, alu_b, alu_op, result, done, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: a=%h b=%h op=%h res=%h done=%b err=%b want all 0",
                     alu_a, alu_b, alu_op, result, done, err);
        end
        model_clear();
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            n_cmp++;
            if (dbg_data !== 32'h0) begin n_fail++; $display("FAIL reset_reg%0d: got %h want 0", i, dbg_data); end
        end
    endtask

    task automatic test_imm_chain();
        bit d, e, me; int lat; logic [31:0] mv;
        model_apply(5'd2, 5'd0, 5'd0, 5'd1, 1'b1, 16'h0070, me, mv);
        do_cmd(5'd2, 5'd0, 5'd0, 5'd1, 1'b1, 16'h0070, d, e, lat);
        n_cmp++;
        if (d !== 1'b1 || lat != 3) begin n_fail++; $display("FAIL chain1_done: done=%b lat=%0d want 1/3", d, lat); end
        n_cmp++;
        if (result !== 32'h70) begin n_fail++; $display("FAIL chain1_result: got %h want 00000070", result); end
        n_cmp++;
        if (alu_op !== 5'd2) begin n_fail++; $display("FAIL chain1_aluop: got %0d want 2", alu_op); end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle: got %b want 0", done); end
        model_apply(5'd2, 5'd1, 5'd0, 5'd2, 1'b1, 16'h0007, me, mv);
        do_cmd(5'd2, 5'd1, 5'd0, 5'd2, 1'b1, 16'h0007, d, e, lat);
        n_cmp++;
        if (d !== 1'b1 || lat != 3) begin n_fail++; $display("FAIL chain2_done: done=%b lat=%0d want 1/3", d, lat); end
        n_cmp++;
        if (result !== 32'h77) begin n_fail++; $display("FAIL chain2_result: got %h want 00000077", result); end
        dbg_addr = 5'd2;
        #1;
        n_cmp++;
        if (dbg_data !== 32'h77) begin n_fail++; $display("FAIL chain_reg2: got %h want 00000077", dbg_data); end
    endtask

    task automatic test_sext_rd0();
        bit d, e, me; int lat; logic [31:0] mv;
        model_apply(5'd2, 5'd0, 5'd0, 5'd3, 1'b1, 16'hFFFF, me, mv);
        do_cmd(5'd2, 5'd0, 5'd0, 5'd3, 1'b1, 16'hFFFF, d, e, lat);
        n_cmp++;
        if (alu_b !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL sext_alub: got %h want ffffffff", alu_b); end
        dbg_addr = 5'd3;
        #1;
        n_cmp++;
        if (dbg_data !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL sext_reg3: got %h want ffffffff", dbg_data); end
        model_apply(5'd2, 5'd0, 5'd0, 5'd0, 1'b1, 16'h1234, me, mv);
        do_cmd(5'd2, 5'd0, 5'd0, 5'd0, 1'b1, 16'h1234, d, e, lat);
        n_cmp++;
        if (d !== 1'b1 || result !== 32'h1234) begin n_fail++; $display("FAIL rd0_done: done=%b res=%h want 1/00001234", d, result); end
        dbg_addr = 5'd0;
        #1;
        n_cmp++;
        if (dbg_data !== 32'h0) begin n_fail++; $display("FAIL rd0_reg0: got %h want 0", dbg_data); end
    endtask

    task automatic test_illegal();
        bit d, e, me; int lat; logic [31:0] mv, sa, sb, sr; logic [4:0] so;
        sa = alu_a; sb = alu_b; so = alu_op; sr = result;
        model_apply(5'd7, 5'd1, 5'd2, 5'd9, 1'b0, 16'h0, me, mv);
        do_cmd(5'd7, 5'd1, 5'd2, 5'd9, 1'b0, 16'h0, d, e, lat);
        n_cmp++;
        if (e !== 1'b1 || d !== 1'b0 || lat != 1) begin n_fail++; $display("FAIL illegal_err: err=%b done=%b lat=%0d want 1/0/1", e, d, lat); end
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse: err=%b done=%b want 0/0", err, done); end
        n_cmp++;
        if (alu_a !== sa || alu_b !== sb || alu_op !== so || result !== sr) begin
            n_fail++;
            $display("FAIL illegal_hold: a=%h b=%h op=%h res=%h want %h %h %h %h", alu_a, alu_b, alu_op, result, sa, sb, so, sr);
        end
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            n_cmp++;
            if (dbg_data !== model_reg[i]) begin n_fail++; $display("FAIL illegal_reg%0d: got %h want %h", i, dbg_data, model_reg[i]); end
        end
        model_apply(5'd6, 5'd2, 5'd0, 5'd7, 1'b1, 16'h0100, me, mv);
        do_cmd(5'd6, 5'd2, 5'd0, 5'd7, 1'b1, 16'h0100, d, e, lat);
        n_cmp++;
        if (d !== 1'b1 || e !== 1'b0 || result !== mv || alu_op !== 5'd6) begin
            n_fail++;
            $display("FAIL op6: done=%b err=%b res=%h op=%0d want 1/0/%h/6", d, e, result, alu_op, mv);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  b_op[4], b_rs[4], b_rt[4], b_rd[4];
        bit          b_ui[4];
        logic [15:0] b_imm[4];
        logic [31:0] exp_v[4];
        bit          me;
        int acc = 0, ndone = 0, last_ready = -1;
        b_op = '{5'd2, 5'd0, 5'd3, 5'd1};
        b_rs = '{5'd0, 5'd4, 5'd4, 5'd6};
        b_rt = '{5'd0, 5'd4, 5'd0, 5'd4};
        b_rd = '{5'd4, 5'd4, 5'd6, 5'd4};
        b_ui = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) b_imm[i] = 16'($urandom);
        for (int i = 0; i < 4; i++)
            model_apply(b_op[i], b_rs[i], b_rt[i], b_rd[i], b_ui[i], b_imm[i], me, exp_v[i]);
        for (int cyc = 0; cyc < 40 && ndone < 4; cyc++) begin
            @(negedge clk);
            if (done) begin
                n_cmp++;
                if (result !== exp_v[ndone]) begin n_fail++; $display("FAIL b2b_result%0d: got %h want %h", ndone, result, exp_v[ndone]); end
                ndone++;
            end
            if (cmd_ready) begin
                if (last_ready >= 0) begin
                    n_cmp++;
                    if (cyc - last_ready != 3) begin n_fail++; $display("FAIL b2b_ready_gap: got %0d want 3", cyc - last_ready); end
                end
                last_ready = cyc;
                if (acc < 4) begin
                    cmd_op = b_op[acc]; cmd_rs = b_rs[acc]; cmd_rt = b_rt[acc]; cmd_rd = b_rd[acc];
                    cmd_use_imm = b_ui[acc]; cmd_imm = b_imm[acc]; cmd_valid = 1'b1;
                    acc++;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        cmd_valid = 1'b0;
        n_cmp++;
        if (ndone != 4 || acc != 4) begin n_fail++; $display("FAIL b2b_count: done=%0d accepted=%0d want 4/4", ndone, acc); end
        dbg_addr = 5'd4;
        #1;
        n_cmp++;
        if (dbg_data !== model_reg[4]) begin n_fail++; $display("FAIL b2b_reg4: got %h want %h", dbg_data, model_reg[4]); end
        dbg_addr = 5'd6;
        #1;
        n_cmp++;
        if (dbg_data !== model_reg[6]) begin n_fail++; $display("FAIL b2b_reg6: got %h want %h", dbg_data, model_reg[6]); end
    endtask

    task automatic test_random();
        bit d, e, me; int lat; logic [31:0] mv, last_res;
        logic [4:0] op, rs, rt, rd; bit ui; logic [15:0] imm;
        for (int n = 0; n < 24; n++) begin
            last_res = result;
            op = 5'($urandom_range(0, 9));
            rs = 5'($urandom_range(0, 31));
            rt = 5'($urandom_range(0, 31));
            rd = 5'($urandom_range(0, 31));
            ui = 1'($urandom_range(0, 1));
            imm = 16'($urandom);
            model_apply(op, rs, rt, rd, ui, imm, me, mv);
            do_cmd(op, rs, rt, rd, ui, imm, d, e, lat);
            n_cmp++;
            if (e !== me || d !== !me) begin n_fail++; $display("FAIL rand%0d_outcome: done=%b err=%b want err=%b", n, d, e, me); end
            n_cmp++;
            if (result !== (me ? last_res : mv)) begin n_fail++; $display("FAIL rand%0d_result: got %h want %h", n, result, me ? last_res : mv); end
            if (!me) begin
                n_cmp++;
                if (lat != 3) begin n_fail++; $display("FAIL rand%0d_latency: got %0d want 3", n, lat); end
            end
        end
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            n_cmp++;
            if (dbg_data !== model_reg[i]) begin n_fail++; $display("FAIL rand_reg%0d: got %h want %h", i, dbg_data, model_reg[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int w = 0, seen_done = 0, seen_err = 0;
        @(negedge clk);
        while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
        cmd_op = 5'd2; cmd_rs = 5'd0; cmd_rt = 5'd0; cmd_rd = 5'd5;
        cmd_use_imm = 1'b1; cmd_imm = 16'h1234; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", cmd_ready); end
        if (done) seen_done++;
        if (err)  seen_err++;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) seen_done++;
            if (err)  seen_err++;
        end
        n_cmp++;
        if (seen_done != 0 || seen_err != 0) begin n_fail++; $display("FAIL midrst_pulses: done=%0d err=%0d want 0/0", seen_done, seen_err); end
        n_cmp++;
        if (result !== 32'h0) begin n_fail++; $display("FAIL midrst_result: got %h want 0", result); end
        dbg_addr = 5'd5;
        #1;
        n_cmp++;
        if (dbg_data !== model_reg[5]) begin n_fail++; $display("FAIL midrst_reg5: got %h want %h", dbg_data, model_reg[5]); end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rs = '0; cmd_rt = '0;
        cmd_rd = '0; cmd_use_imm = 1'b0; cmd_imm = '0; dbg_addr = '0;
        test_reset();
        test_imm_chain();
        test_sext_rd0();
        test_illegal();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
